// File: rtl/fetch_unit.sv
// IF-stage fetch sequencer: drives the fetch PC to the predictor, runs the imem req/gnt/rvalid handshake
// with at most one request outstanding, and fills the IF/ID register. Optional perf counters: FETCH_PERF_CNT_EN.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [31:0] pcF,
    input  logic [31:0] next_pc_predF,
    input  logic        pred_takenF,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stallD,
    input  logic        redirectE,
    input  logic [31:0] redirect_pcE,
    output logic        validD,
    output logic [31:0] instrD,
    output logic [31:0] pcD,
    output logic        pred_takenD,
    output logic [31:0] pred_nextD,
    output logic [31:0] fetch_countO,
    output logic [31:0] redirect_countO
);
    localparam logic [31:0] NOP = 32'h0000_0013;

    // Handshake: a request is accepted on a cycle with imem_req & imem_gnt; exactly one
    // imem_rvalid follows at least one cycle later. IF/ID accepts when !validD | !stallD.
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DRAIN} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] fl_pc_q, fl_pc_d;
    logic [31:0] fl_next_q, fl_next_d;
    logic        fl_taken_q, fl_taken_d;
    logic        skid_valid_q, skid_valid_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcd_q, pcd_d;
    logic        ptaken_q, ptaken_d;
    logic [31:0] pnext_q, pnext_d;
    logic        load;
    logic [31:0] load_instr;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        fl_pc_d      = fl_pc_q;
        fl_next_d    = fl_next_q;
        fl_taken_d   = fl_taken_q;
        skid_valid_d = skid_valid_q;
        skid_instr_d = skid_instr_q;
        valid_d      = valid_q;
        instr_d      = instr_q;
        pcd_d        = pcd_q;
        ptaken_d     = ptaken_q;
        pnext_d      = pnext_q;
        load         = 1'b0;
        load_instr   = imem_rdata;

        case (state_q)
            S_REQ: begin
                if (imem_gnt && !redirectE) begin
                    fl_pc_d    = pc_q;
                    fl_next_d  = next_pc_predF;
                    fl_taken_d = pred_takenF;
                    pc_d       = next_pc_predF;
                    state_d    = S_WAIT;
                end else if (imem_gnt) begin
                    state_d = S_DRAIN;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    if (redirectE) begin
                        state_d = S_REQ;
                    end else if (!valid_q || !stallD) begin
                        load    = 1'b1;
                        state_d = S_REQ;
                    end else begin
                        skid_valid_d = 1'b1;
                        skid_instr_d = imem_rdata;
                        state_d      = S_HOLD;
                    end
                end else if (redirectE) begin
                    state_d = S_DRAIN;
                end
            end
            S_HOLD: begin
                if (redirectE) begin
                    state_d = S_REQ;
                end else if (!stallD) begin
                    load         = 1'b1;
                    load_instr   = skid_instr_q;
                    skid_valid_d = 1'b0;
                    state_d      = S_REQ;
                end
            end
            S_DRAIN: begin
                // The stale response ends the drain even if another redirect lands on it;
                // no further response is outstanding, so waiting longer would deadlock.
                if (imem_rvalid) state_d = S_REQ;
            end
            default: state_d = S_REQ;
        endcase

        if (redirectE) begin
            pc_d         = {redirect_pcE[31:2], 2'b00};
            skid_valid_d = 1'b0;
            valid_d      = 1'b0;
        end else if (load) begin
            valid_d  = 1'b1;
            instr_d  = load_instr;
            pcd_d    = fl_pc_q;
            ptaken_d = fl_taken_q;
            pnext_d  = fl_next_q;
        end else if (valid_q && !stallD) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            fl_pc_q      <= '0;
            fl_next_q    <= '0;
            fl_taken_q   <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_instr_q <= '0;
            valid_q      <= 1'b0;
            instr_q      <= NOP;
            pcd_q        <= '0;
            ptaken_q     <= 1'b0;
            pnext_q      <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            fl_pc_q      <= fl_pc_d;
            fl_next_q    <= fl_next_d;
            fl_taken_q   <= fl_taken_d;
            skid_valid_q <= skid_valid_d;
            skid_instr_q <= skid_instr_d;
            valid_q      <= valid_d;
            instr_q      <= instr_d;
            pcd_q        <= pcd_d;
            ptaken_q     <= ptaken_d;
            pnext_q      <= pnext_d;
        end
    end

    assign pcF         = pc_q;
    assign imem_addr   = pc_q;
    assign imem_req    = reset_n && (state_q == S_REQ);
    assign validD      = valid_q;
    assign instrD      = instr_q;
    assign pcD         = pcd_q;
    assign pred_takenD = ptaken_q;
    assign pred_nextD  = pnext_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] redir_cnt_q, redir_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q + {31'd0, load};
        redir_cnt_d = redir_cnt_q + {31'd0, redirectE};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_cnt_q <= '0;
            redir_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            redir_cnt_q <= redir_cnt_d;
        end
    end

    assign fetch_countO    = fetch_cnt_q;
    assign redirect_countO = redir_cnt_q;
`else
    assign fetch_countO    = 32'h0;
    assign redirect_countO = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: memory and predictor stand-ins, a fetch-PC model and an
// expected queue of IF/ID contents popped whenever decode consumes the IF/ID register.
module tb_fetch_unit;
    localparam logic [31:0] RPC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] pcF, next_pc_predF, imem_addr, imem_rdata, redirect_pcE;
    logic [31:0] instrD, pcD, pred_nextD, fetch_countO, redirect_countO;
    logic        pred_takenF, imem_req, imem_gnt, imem_rvalid, stallD, redirectE;
    logic        validD, pred_takenD;

    int          checks = 0;
    int          errors = 0;
    int          loaded = 0;
    int          redirects = 0;
    logic        gnt_en = 1'b0;
    logic        take_en = 1'b0;
    logic [31:0] model_pc;
    logic [96:0] exp_q[$];
    logic [31:0] mem_q[$];

    fetch_unit #(.RESET_PC(RPC)) dut (
        .clk(clk), .reset_n(reset_n), .pcF(pcF), .next_pc_predF(next_pc_predF),
        .pred_takenF(pred_takenF), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .stallD(stallD), .redirectE(redirectE), .redirect_pcE(redirect_pcE),
        .validD(validD), .instrD(instrD), .pcD(pcD), .pred_takenD(pred_takenD),
        .pred_nextD(pred_nextD), .fetch_countO(fetch_countO), .redirect_countO(redirect_countO)
    );

    always #5 clk = ~clk;

    function automatic logic taken_of(input logic [31:0] pc);
        return take_en && (pc == 32'h0000_0104);
    endfunction

    function automatic logic [31:0] next_of(input logic [31:0] pc);
        return taken_of(pc) ? 32'h0000_0200 : pc + 32'd4;
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // predictor stand-in
    assign pred_takenF   = taken_of(pcF);
    assign next_pc_predF = next_of(pcF);

    // Called at a negedge: sample, drive this cycle's inputs, advance the models, wait for the next negedge.
    task automatic cycle(input logic st, input logic rd, input logic [31:0] rpc);
        logic [96:0] e;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        if (mem_q.size() != 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(mem_q.pop_front());
        end
        stallD       = st;
        redirectE    = rd;
        redirect_pcE = rpc;
        imem_gnt     = gnt_en;
        if (imem_req) begin
            checks++;
            if (imem_addr !== model_pc || pcF !== model_pc) begin
                errors++;
                $display("FAIL fetch_addr: imem_addr %h pcF %h expected %h", imem_addr, pcF, model_pc);
            end
        end
        if (validD && !st) begin
            loaded++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL ifid_unexpected: pcD %h instrD %h expected nothing", pcD, instrD);
            end else begin
                e = exp_q.pop_front();
                if ({pcD, pred_nextD, pred_takenD, instrD} !== e) begin
                    errors++;
                    $display("FAIL ifid_data: got pc %h next %h tk %b instr %h expected pc %h next %h tk %b instr %h",
                             pcD, pred_nextD, pred_takenD, instrD, e[96:65], e[64:33], e[32], e[31:0]);
                end
            end
        end else if (validD && rd) begin
            loaded++;
        end
        if (rd) begin
            redirects++;
            exp_q.delete();
            if (imem_req && gnt_en) mem_q.push_back(model_pc);
            model_pc = {rpc[31:2], 2'b00};
        end else if (imem_req && gnt_en) begin
            exp_q.push_back({model_pc, next_of(model_pc), taken_of(model_pc), mem_word(model_pc)});
            mem_q.push_back(model_pc);
            model_pc = next_of(model_pc);
        end
        @(negedge clk);
    endtask

    task automatic drain();
        gnt_en = 1'b0;
        repeat (4) cycle(1'b0, 1'b0, 32'h0);
        checks++;
        if (exp_q.size() != 0 || validD !== 1'b0) begin
            errors++;
            $display("FAIL drain: left %0d validD %b expected 0 0", exp_q.size(), validD);
        end
        gnt_en = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0;
        stallD = 0; redirectE = 0; redirect_pcE = 0;
        model_pc = RPC;
        repeat (2) @(negedge clk);
        checks++;
        if ({validD, instrD, pcD, pred_takenD, pred_nextD, imem_req, pcF, imem_addr, fetch_countO, redirect_countO}
            !== {1'b0, 32'h13, 32'h0, 1'b0, 32'h0, 1'b0, RPC, RPC, 32'h0, 32'h0}) begin
            errors++;
            $display("FAIL reset_state: v %b i %h pc %h tk %b nx %h req %b pcF %h fc %h rc %h", validD, instrD,
                     pcD, pred_takenD, pred_nextD, imem_req, pcF, fetch_countO, redirect_countO);
        end
        reset_n = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_req: got %b expected 1", imem_req);
        end
        @(negedge clk);
    endtask

    task automatic test_basic();
        int highs = 0;
        gnt_en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cycle(1'b0, 1'b0, 32'h0);
            if (validD === 1'b1) highs++;
        end
        checks++;
        if (highs != 6) begin
            errors++;
            $display("FAIL basic_rate: validD high %0d cycles expected 6", highs);
        end
        drain();
    endtask

    task automatic test_predict();
        take_en = 1'b1;
        gnt_en  = 1'b0;
        cycle(1'b0, 1'b1, 32'h0000_0104);
        gnt_en = 1'b1;
        repeat (10) cycle(1'b0, 1'b0, 32'h0);
        drain();
        take_en = 1'b0;
    endtask

    task automatic test_stall();
        int n = 0;
        while (validD !== 1'b1 && n < 10) begin
            cycle(1'b0, 1'b0, 32'h0);
            n++;
        end
        checks++;
        if (validD !== 1'b1) begin
            errors++;
            $display("FAIL stall_setup_timeout: validD %b expected 1", validD);
        end else begin
            logic [31:0] hold_pc, hold_instr;
            hold_pc    = exp_q[0][96:65];
            hold_instr = exp_q[0][31:0];
            repeat (3) cycle(1'b1, 1'b0, 32'h0);
            checks++;
            if ({imem_req, validD, pcD, instrD} !== {1'b0, 1'b1, hold_pc, hold_instr}) begin
                errors++;
                $display("FAIL stall_hold: req %b v %b pc %h instr %h expected 0 1 %h %h",
                         imem_req, validD, pcD, instrD, hold_pc, hold_instr);
            end
            cycle(1'b0, 1'b0, 32'h0);
            checks++;
            if (exp_q.size() == 0 || validD !== 1'b1 || pcD !== exp_q[0][96:65]) begin
                errors++;
                $display("FAIL skid_load: v %b pcD %h expected 1 %h", validD, pcD, hold_pc + 32'd4);
            end
        end
        drain();
    endtask

    task automatic test_redirect_gnt();
        int n = 0;
        while (imem_req !== 1'b1 && n < 10) begin
            cycle(1'b0, 1'b0, 32'h0);
            n++;
        end
        cycle(1'b0, 1'b1, 32'h0000_0403);
        checks++;
        if (validD !== 1'b0 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL redir_gnt_drain: v %b req %b expected 0 0", validD, imem_req);
        end
        cycle(1'b0, 1'b0, 32'h0);
        checks++;
        if (validD !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0000_0400) begin
            errors++;
            $display("FAIL redir_gnt_resume: v %b req %b addr %h expected 0 1 00000400", validD, imem_req, imem_addr);
        end
        repeat (4) cycle(1'b0, 1'b0, 32'h0);
        drain();
    endtask

    task automatic test_redirect_rvalid();
        int n = 0;
        while (mem_q.size() == 0 && n < 10) begin
            cycle(1'b0, 1'b0, 32'h0);
            n++;
        end
        cycle(1'b0, 1'b1, 32'h0000_0300);
        checks++;
        if (validD !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0000_0300) begin
            errors++;
            $display("FAIL redir_rvalid: v %b req %b addr %h expected 0 1 00000300", validD, imem_req, imem_addr);
        end
        n = 0;
        while (validD !== 1'b1 && n < 10) begin
            cycle(1'b0, 1'b0, 32'h0);
            n++;
        end
        cycle(1'b1, 1'b1, 32'h0000_0500);
        checks++;
        if (validD !== 1'b0) begin
            errors++;
            $display("FAIL redir_stall_flush: validD %b expected 0", validD);
        end
        repeat (6) cycle(1'b0, 1'b0, 32'h0);
        drain();
    endtask

    task automatic test_wrap();
        gnt_en = 1'b0;
        cycle(1'b0, 1'b1, 32'hFFFF_FFFF);
        gnt_en = 1'b1;
        for (int i = 0; i < 8; i++) cycle(1'b0, ($urandom_range(0, 3) == 0), 32'h0);
        drain();
    endtask

    task automatic test_reset_mid();
        int n = 0;
        while (mem_q.size() == 0 && n < 10) begin
            cycle(1'b0, 1'b0, 32'h0);
            n++;
        end
        #2 reset_n = 1'b0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; stallD = 1'b0; redirectE = 1'b0;
        mem_q.delete(); exp_q.delete();
        model_pc = RPC; loaded = 0; redirects = 0;
        #1;
        checks++;
        if ({validD, imem_req, pcF, fetch_countO, redirect_countO} !== {1'b0, 1'b0, RPC, 32'h0, 32'h0}) begin
            errors++;
            $display("FAIL reset_mid: v %b req %b pcF %h fc %h rc %h expected 0 0 %h 0 0",
                     validD, imem_req, pcF, fetch_countO, redirect_countO, RPC);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== RPC) begin
            errors++;
            $display("FAIL reset_mid_first_req: req %b addr %h expected 1 %h", imem_req, imem_addr, RPC);
        end
        @(negedge clk);
    endtask

    task automatic test_counters();
        gnt_en = 1'b1;
        for (int i = 0; i < 30; i++)
            cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0), 32'h100 + 32'($urandom_range(0, 64)) * 4);
        drain();
        checks++;
`ifdef FETCH_PERF_CNT_EN
        if (fetch_countO !== 32'(loaded) || redirect_countO !== 32'(redirects)) begin
            errors++;
            $display("FAIL counters: fc %0d rc %0d expected %0d %0d", fetch_countO, redirect_countO, loaded, redirects);
        end
`else
        if (fetch_countO !== 32'h0 || redirect_countO !== 32'h0) begin
            errors++;
            $display("FAIL counters_off: fc %h rc %h expected 0 0", fetch_countO, redirect_countO);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_predict();
        test_stall();
        test_redirect_gnt();
        test_redirect_rvalid();
        test_wrap();
        test_reset_mid();
        test_counters();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- IF-stage fetch sequencer, sitting directly upstream of the 2-bit BHT/BTB predictor.
- Holds the fetch PC, drives it to the predictor (pcF), and advances the PC to the predictor's next_pc_predF.
- Issues requests to the instruction memory over a req/gnt/rvalid handshake with at most one request outstanding.
- Delivers instruction, PC and prediction info into the IF/ID register; applies EX-stage mispredict redirects and decode stalls.

Parameters:
RESET_PC, 32'h0000_0000, PC fetched first after reset release (bits [1:0] must be 0)

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
pcF  out  32  current fetch PC, to predictor
next_pc_predF  in  32  predicted next PC from predictor
pred_takenF  in  1  predictor taken flag for pcF
imem_req  out  1  fetch request
imem_addr  out  32  fetch address (= pcF)
imem_gnt  in  1  memory accepted request this cycle
imem_rvalid  in  1  read data valid (one per granted request, ≥1 cycle after gnt)
imem_rdata  in  32  instruction word
stallD  in  1  decode cannot accept; hold IF/ID
redirectE  in  1  EX mispredict/jump, overrides everything
redirect_pcE  in  32  correct PC; bits [1:0] ignored (forced 0)
validD  out  1  IF/ID holds a valid instruction
instrD  out  32  instruction
pcD  out  32  PC of instrD
pred_takenD  out  1  prediction used for instrD
pred_nextD  out  32  predicted next PC for instrD (EX compares it against the actual next PC)
fetch_countO  out  32  perf: instructions delivered to IF/ID
redirect_countO  out  32  perf: redirects applied

Behaviour:
- Reset, asynchronous, while reset_n=0:
  - pc=RESET_PC, state=S_REQ, validD=0, skid empty.
  - instrD=32'h0000_0013 (NOP), pcD=0, pred_takenD=0, pred_nextD=0, counters=0.
  - imem_req=0 during reset.
- Outputs: pcF=imem_addr=pc at all times. imem_req=1 only in S_REQ.
- S_REQ:
  - On imem_gnt & !redirectE: latch pc, pred_takenF, next_pc_predF into in-flight regs; pc<=next_pc_predF; go to S_WAIT.
  - Without gnt: hold pc and keep imem_req asserted.
- S_WAIT, on imem_rvalid:
  - If IF/ID can accept (!validD | !stallD): load IF/ID from in-flight regs plus imem_rdata; validD<=1; go to S_REQ.
  - Otherwise: store into the one-entry skid; go to S_HOLD.
- S_HOLD: when !stallD, move skid into IF/ID and go to S_REQ. imem_req=0 in this state.
- IF/ID consumption: when validD & !stallD and no new load is available, validD<=0. When stallD=1, IF/ID holds all fields unchanged.
- Redirect (redirectE=1), highest priority, in any state:
  - pc<={redirect_pcE[31:2],2'b00}; validD<=0; skid cleared.
  - S_REQ with imem_gnt in the same cycle: the request is consumed by memory, so go to S_DRAIN.
  - S_REQ without gnt: stay in S_REQ with the new pc.
  - S_WAIT without rvalid: go to S_DRAIN. S_WAIT with rvalid in the same cycle: drop the data; go to S_REQ.
  - S_HOLD: go to S_REQ.
  - S_DRAIN: stay in S_DRAIN and update pc.
- S_DRAIN: imem_req=0; discard the next imem_rvalid, then go to S_REQ.
- Redirect with stallD=1: the flush still wins (validD<=0).
- Throughput: at most one instruction per 2 cycles with a single-cycle memory. PC arithmetic is 32-bit wrap-around; the predictor supplies the +4.
- imem_rvalid outside S_WAIT/S_DRAIN is a protocol error and is ignored.

Optional Feature:
FETCH_PERF_CNT_EN
- Defined:
  - fetch_countO increments on each IF/ID load, including loads from the skid.
  - redirect_countO increments on each cycle with redirectE=1.
  - Both are 32-bit wrapping counters, reset to 0.
- Undefined: both outputs tied to 32'h0 and no counter flops are inferred.

Test Plan:
- Reset release, RESET_PC=0x100, gnt=1, rvalid one cycle later, predictor not-taken (next=pc+4) -> IF/ID receives pcD=0x100,0x104,0x108 with validD pulsing every 2nd cycle; pred_takenD=0.
- Predictor returns pred_taken=1, next=0x200 for pc=0x104 -> pcD=0x104 has pred_nextD=0x200; the next fetch address is 0x200.
- stallD=1 held 3 cycles while rvalid arrives for 0x108 -> word held in skid, imem_req=0; IF/ID unchanged; after stallD drops, pcD=0x108 loads the next cycle.
- redirectE=1, redirect_pcE=0x403 in the same cycle as gnt for 0x10C -> validD=0, S_DRAIN, the 0x10C response discarded; next imem_addr=0x400.
- redirectE coincident with rvalid in S_WAIT -> data dropped, validD=0, imem_req=1 next cycle at the redirect pc.
- reset_n asserted mid-S_WAIT, then released -> validD=0, the first request is to RESET_PC; with FETCH_PERF_CNT_EN defined, counters read 0 after reset and equal to loads/redirects afterwards.
